// File: rtl/m_dmem_responder.sv
// Word-addressed data memory that answers valid/ready load/store requests.
// Each request gets one response a fixed number of clock edges after it is accepted.
module m_dmem_responder #(
    parameter int ADDR_W     = 12,
    parameter int LATENCY    = 2,
    parameter int INIT_IMAGE = 1
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_req_valid,
    output logic              w_req_ready,
    input  logic              w_req_we,
    input  logic [ADDR_W-1:0] w_req_addr,
    input  logic [31:0]       w_req_wdata,
    input  logic [3:0]        w_req_be,
    output logic              w_rsp_valid,
    input  logic              w_rsp_ready,
    output logic [31:0]       w_rsp_rdata,
    output logic              w_rsp_we,
    output logic              w_busy
);
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("m_dmem_responder: LATENCY must be in 1..15");
    end

    // The program image places words at 0x010 and 0x020, so the array must reach them.
    if (ADDR_W < 6) begin : g_bad_addr_w
        $error("m_dmem_responder: ADDR_W must be at least 6");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] rdata_reg;
    logic        we_reg;
    logic        accept;
    logic [31:0] rd_word;
    logic [31:0] wr_word;

    // Program image; with INIT_IMAGE = 0 the contents carry no meaning.
    logic [31:0] mem_reg [DEPTH] = '{
        16:      (INIT_IMAGE != 0) ? 32'h1234_5678 : 32'h0,
        32:      (INIT_IMAGE != 0) ? 32'h1122_3344 : 32'h0,
        default: 32'h0
    };

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        w_req_ready = 1'b0;
        accept      = 1'b0;
        case (state_reg)
            ST_IDLE: w_req_ready = 1'b1;
            ST_WAIT: begin
                if (cnt_reg == 4'd1) begin
                    state_next = ST_RESP;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_RESP: begin
                w_req_ready = w_rsp_ready;
                if (w_rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (!w_rst_n) begin
            w_req_ready = 1'b0;
        end
        accept = w_req_valid && w_req_ready;
        // A new acceptance (from IDLE or on the consuming edge in RESP) restarts the latency.
        if (accept) begin
            if (LATENCY == 1) begin
                state_next = ST_RESP;
                cnt_next   = 4'd0;
            end else begin
                state_next = ST_WAIT;
                cnt_next   = CNT_LOAD;
            end
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            rdata_reg <= 32'h0;
            we_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                rdata_reg <= rd_word;
                we_reg    <= w_req_we;
            end
        end
    end

    // Byte-enable merge: disabled lanes keep the word currently stored.
    assign rd_word = mem_reg[w_req_addr];
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_byte
        assign wr_word[8*gi +: 8] = w_req_be[gi] ? w_req_wdata[8*gi +: 8] : rd_word[8*gi +: 8];
    end

    always_ff @(posedge w_clk) begin
        if (accept && w_req_we) begin
            mem_reg[w_req_addr] <= wr_word;
        end
    end

    assign w_rsp_valid = (state_reg == ST_RESP);
    assign w_rsp_rdata = rdata_reg;
    assign w_rsp_we    = we_reg;
    assign w_busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_m_dmem_responder.sv
// Bench for m_dmem_responder: one instance at LATENCY 2, one at LATENCY 1, each checked
// against a word-array memory model plus the expected response timing.
module tb_m_dmem_responder;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n     [2];
    logic              req_valid [2];
    logic              req_ready [2];
    logic              req_we    [2];
    logic [ADDR_W-1:0] req_addr  [2];
    logic [31:0]       req_wdata [2];
    logic [3:0]        req_be    [2];
    logic              rsp_valid [2];
    logic              rsp_ready [2];
    logic [31:0]       rsp_rdata [2];
    logic              rsp_we    [2];
    logic              busy      [2];

    int          lat [2];
    logic [31:0] model [2][DEPTH];
    int          vectors     = 0;
    int          miscompares = 0;

    m_dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(2), .INIT_IMAGE(1)) dut0 (
        .w_clk(clk), .w_rst_n(rst_n[0]),
        .w_req_valid(req_valid[0]), .w_req_ready(req_ready[0]), .w_req_we(req_we[0]),
        .w_req_addr(req_addr[0]), .w_req_wdata(req_wdata[0]), .w_req_be(req_be[0]),
        .w_rsp_valid(rsp_valid[0]), .w_rsp_ready(rsp_ready[0]), .w_rsp_rdata(rsp_rdata[0]),
        .w_rsp_we(rsp_we[0]), .w_busy(busy[0])
    );

    m_dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(1), .INIT_IMAGE(1)) dut1 (
        .w_clk(clk), .w_rst_n(rst_n[1]),
        .w_req_valid(req_valid[1]), .w_req_ready(req_ready[1]), .w_req_we(req_we[1]),
        .w_req_addr(req_addr[1]), .w_req_wdata(req_wdata[1]), .w_req_be(req_be[1]),
        .w_rsp_valid(rsp_valid[1]), .w_rsp_ready(rsp_ready[1]), .w_rsp_rdata(rsp_rdata[1]),
        .w_rsp_we(rsp_we[1]), .w_busy(busy[1])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: accept, wait out the latency, hold under backpressure, consume.
    task automatic do_txn(input int i, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int hold);
        logic [31:0] exp_rdata;
        int n;
        exp_rdata = model[i][addr];
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model[i][addr][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        vectors++;
        if (req_ready[i] !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_ready inst=%0d: got %b want 1", i, req_ready[i]);
        end
        req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = addr;
        req_wdata[i] = wdata; req_be[i] = be;
        step();
        // Garbage on the request bus while busy must be ignored.
        req_valid[i] = 1'b0; req_we[i] = ~we; req_addr[i] = ADDR_W'($urandom);
        req_wdata[i] = $urandom; req_be[i] = 4'($urandom);
        n = 1;
        while (rsp_valid[i] !== 1'b1 && n < 40) begin
            vectors++;
            if (req_ready[i] !== 1'b0 || busy[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL wait_state inst=%0d: got ready=%b busy=%b want ready=0 busy=1",
                         i, req_ready[i], busy[i]);
            end
            step();
            n++;
        end
        vectors++;
        if (n != lat[i]) begin
            miscompares++;
            $display("FAIL latency inst=%0d: got %0d edges want %0d", i, n, lat[i]);
        end
        for (int h = 0; h <= hold; h++) begin
            vectors++;
            if (rsp_valid[i] !== 1'b1 || rsp_rdata[i] !== exp_rdata || rsp_we[i] !== we ||
                req_ready[i] !== 1'b0 || busy[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL resp_hold inst=%0d cyc=%0d: got v=%b d=%08h we=%b rdy=%b busy=%b want v=1 d=%08h we=%b rdy=0 busy=1",
                         i, h, rsp_valid[i], rsp_rdata[i], rsp_we[i], req_ready[i], busy[i], exp_rdata, we);
            end
            if (h < hold) step();
        end
        rsp_ready[i] = 1'b1;
        #1;
        vectors++;
        if (req_ready[i] !== 1'b1) begin
            miscompares++;
            $display("FAIL resp_ready_follow inst=%0d: got %b want 1", i, req_ready[i]);
        end
        step();
        rsp_ready[i] = 1'b0;
        vectors++;
        if (rsp_valid[i] !== 1'b0 || busy[i] !== 1'b0) begin
            miscompares++;
            $display("FAIL consume inst=%0d: got v=%b busy=%b want 0 0", i, rsp_valid[i], busy[i]);
        end
        $display("txn inst=%0d we=%0d addr=%03h wdata=%08h be=%b rdata=%08h exp=%08h lat=%0d hold=%0d",
                 i, we, addr, wdata, be, rsp_rdata[i], exp_rdata, n, hold);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b1; req_valid[i] = 1'b1; req_we[i] = 1'b0; req_addr[i] = '0;
            req_wdata[i] = '0; req_be[i] = '0; rsp_ready[i] = 1'b0;
        end
        #2;
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        step(); step();
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (req_ready[i] !== 1'b0 || rsp_valid[i] !== 1'b0 || rsp_rdata[i] !== 32'h0 ||
                rsp_we[i] !== 1'b0 || busy[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state inst=%0d: got rdy=%b v=%b d=%08h we=%b busy=%b want all 0",
                         i, req_ready[i], rsp_valid[i], rsp_rdata[i], rsp_we[i], busy[i]);
            end
            req_valid[i] = 1'b0;
        end
        #2;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (req_ready[i] !== 1'b1 || busy[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset inst=%0d: got rdy=%b busy=%b want 1 0", i, req_ready[i], busy[i]);
            end
            $display("txn inst=%0d reset released", i);
        end
    endtask

    task automatic test_load_store();
        do_txn(0, 1'b0, 12'h010, 32'h0, 4'h0, 0);
        do_txn(0, 1'b1, 12'h020, 32'hAABBCCDD, 4'b0101, 0);
        do_txn(0, 1'b0, 12'h020, 32'h0, 4'hF, 0);
        vectors++;
        if (model[0][12'h020] !== 32'h11BB33DD) begin
            miscompares++;
            $display("FAIL model_merge: got %08h want 11bb33dd", model[0][12'h020]);
        end
    endtask

    task automatic test_backpressure();
        do_txn(0, 1'b0, 12'h010, 32'h0, 4'h0, 5);
    endtask

    task automatic test_back_to_back();
        logic [31:0] old_word;
        old_word = model[0][12'h030];
        model[0][12'h030] = 32'h0000CAFE;
        rsp_ready[0] = 1'b1;
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 12'h030;
        req_wdata[0] = 32'h0000CAFE; req_be[0] = 4'hF;
        step();
        req_we[0] = 1'b0; req_wdata[0] = $urandom; req_be[0] = 4'($urandom);
        vectors++;
        if (rsp_valid[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_edge1: got v=%b want 0", rsp_valid[0]);
        end
        step();
        vectors++;
        if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== old_word || rsp_we[0] !== 1'b1 || req_ready[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first_rsp: got v=%b d=%08h we=%b rdy=%b want 1 %08h 1 1",
                     rsp_valid[0], rsp_rdata[0], rsp_we[0], req_ready[0], old_word);
        end
        step();
        req_valid[0] = 1'b0;
        vectors++;
        if (rsp_valid[0] !== 1'b0 || busy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_reaccept: got v=%b busy=%b want 0 1", rsp_valid[0], busy[0]);
        end
        step();
        vectors++;
        if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'h0000CAFE || rsp_we[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second_rsp: got v=%b d=%08h we=%b want 1 0000cafe 0",
                     rsp_valid[0], rsp_rdata[0], rsp_we[0]);
        end
        step();
        rsp_ready[0] = 1'b0;
        vectors++;
        if (rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: got v=%b busy=%b want 0 0", rsp_valid[0], busy[0]);
        end
        $display("txn inst=0 back-to-back store/load 030 rdata=%08h", rsp_rdata[0]);
    endtask

    task automatic test_latency1();
        do_txn(1, 1'b0, 12'h010, 32'h0, 4'h0, 0);
        do_txn(1, 1'b1, 12'h050, 32'h5555AAAA, 4'hF, 0);
        do_txn(1, 1'b1, 12'h050, 32'h12345678, 4'h0, 1);
        do_txn(1, 1'b0, 12'h050, 32'h0, 4'hF, 0);
    endtask

    task automatic test_reset_mid_op();
        // Reset while the store waits out its latency.
        model[0][12'h040] = 32'hDEADBEEF;
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 12'h040;
        req_wdata[0] = 32'hDEADBEEF; req_be[0] = 4'hF;
        step();
        req_valid[0] = 1'b0;
        vectors++;
        if (busy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_wait_busy: got %b want 1", busy[0]);
        end
        #2 rst_n[0] = 1'b0;
        #1;
        vectors++;
        if (busy[0] !== 1'b0 || rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_wait: got busy=%b v=%b rdy=%b want 0 0 0", busy[0], rsp_valid[0], req_ready[0]);
        end
        #3 rst_n[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            vectors++;
            if (rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL no_stale_rsp cyc=%0d: got v=%b busy=%b want 0 0", k, rsp_valid[0], busy[0]);
            end
        end
        do_txn(0, 1'b0, 12'h040, 32'h0, 4'h0, 0);
        // Reset while a response is being presented.
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 12'h010;
        step();
        req_valid[1] = 1'b0;
        #2 rst_n[1] = 1'b0;
        #1;
        vectors++;
        if (rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'h0 || busy[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_resp: got v=%b d=%08h busy=%b want 0 00000000 0", rsp_valid[1], rsp_rdata[1], busy[1]);
        end
        #3 rst_n[1] = 1'b1;
        step();
        $display("txn inst=0/1 mid-operation resets done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 2; i++) begin
            for (int t = 0; t < 40; t++) begin
                do_txn(i, 1'($urandom), 12'h100 + 12'($urandom_range(0, 15)), $urandom,
                       4'($urandom), $urandom_range(0, 3));
            end
        end
    endtask

    initial begin
        lat[0] = 2;
        lat[1] = 1;
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < DEPTH; a++) model[i][a] = 32'h0;
            model[i][12'h010] = 32'h12345678;
            model[i][12'h020] = 32'h11223344;
        end
        test_reset();
        test_load_store();
        test_backpressure();
        test_back_to_back();
        test_latency1();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
